// File: rtl/led_pattern_gen_if.sv
// rtl/led_pattern_gen_if.sv - control/pattern bundle between a controller and led_pattern_gen
//
// Signals:
//   i_enable    : 1 = pattern runs, 0 = pattern freezes
//   i_speed_sel : step-rate select (LIMIT_0..LIMIT_3)
//   i_mode      : 0 = shift, 1 = flash (synchronous level)
//   i_dir_btn   : raw asynchronous push-button, each press reverses shift direction
//   o_led       : registered pattern word, 1:1 to ledmux i_led
//   o_tick      : registered one-cycle strobe on every pattern step
// Modports:
//   master : drives the controls, observes the pattern
//   slave  : the pattern generator itself

interface led_pattern_gen_if #(
  parameter int N_LEDS = 4
);
  logic              i_enable;
  logic [1:0]        i_speed_sel;
  logic              i_mode;
  logic              i_dir_btn;
  logic [N_LEDS-1:0] o_led;
  logic              o_tick;

  modport master (
    output i_enable, i_speed_sel, i_mode, i_dir_btn,
    input  o_led, o_tick
  );

  modport slave (
    input  i_enable, i_speed_sel, i_mode, i_dir_btn,
    output o_led, o_tick
  );
endinterface

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - shift/flash LED pattern generator with prescaled step rate
//
// Ports:
//   clk     : system clock, all state on the rising edge
//   i_rst_n : asynchronous assert, synchronous release, active-low reset
//   bus     : led_pattern_gen_if.slave
//             (i_enable, i_speed_sel, i_mode, i_dir_btn in; o_led, o_tick out)
//
// A free-running prescaler counts to the selected terminal count and issues a
// step. In shift mode a single lit LED rotates; in flash mode the whole bank
// toggles. A mode change reloads the pattern and restarts the prescaler.

module led_pattern_gen #(
  parameter int                    N_LEDS     = 4,
  parameter int                    NB_COUNTER = 32,
  parameter logic [NB_COUNTER-1:0] LIMIT_0    = NB_COUNTER'(2**23 - 1),
  parameter logic [NB_COUNTER-1:0] LIMIT_1    = NB_COUNTER'(2**24 - 1),
  parameter logic [NB_COUNTER-1:0] LIMIT_2    = NB_COUNTER'(2**25 - 1),
  parameter logic [NB_COUNTER-1:0] LIMIT_3    = NB_COUNTER'(2**26 - 1)
) (
  input  logic                clk,
  input  logic                i_rst_n,
  led_pattern_gen_if.slave    bus
);

  typedef enum logic {MODE_SHIFT = 1'b0, MODE_FLASH = 1'b1} mode_t;
  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1}    dir_t;

  localparam logic [N_LEDS-1:0] LED_ONE = N_LEDS'(1);

  logic [NB_COUNTER-1:0] counter_q;
  logic [NB_COUNTER-1:0] limit_sel;
  logic [N_LEDS-1:0]     led_q;
  logic                  tick_q;
  mode_t                 mode_q;
  mode_t                 mode_req;
  dir_t                  dir_q;
  logic                  phase_q;
  logic                  btn_s1_q;
  logic                  btn_s2_q;
  logic                  btn_d_q;
  logic                  btn_rise;
  logic                  terminal;

  always_comb begin
    limit_sel = LIMIT_0;
    case (bus.i_speed_sel)
      2'd0:    limit_sel = LIMIT_0;
      2'd1:    limit_sel = LIMIT_1;
      2'd2:    limit_sel = LIMIT_2;
      default: limit_sel = LIMIT_3;
    endcase
  end

  // '>=' so that lowering the speed selection below the current count
  // fires on the next cycle instead of running the counter round.
  assign terminal = (counter_q >= limit_sel);
  assign btn_rise = btn_s2_q & ~btn_d_q;
  assign mode_req = mode_t'(bus.i_mode);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      counter_q <= '0;
      tick_q    <= 1'b0;
      led_q     <= LED_ONE;
      mode_q    <= MODE_SHIFT;
      dir_q     <= DIR_LEFT;
      phase_q   <= 1'b0;
      btn_s1_q  <= 1'b0;
      btn_s2_q  <= 1'b0;
      btn_d_q   <= 1'b0;
    end else begin
      btn_s1_q <= bus.i_dir_btn;
      btn_s2_q <= btn_s1_q;
      btn_d_q  <= btn_s2_q;

      // The step below reads the pre-toggle dir_q, so a toggle landing on a
      // tick only affects the following step.
      if (btn_rise) begin
        dir_q <= (dir_q == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
      end

      if (mode_req != mode_q) begin
        // Mode load has priority over any terminal count and ignores enable.
        mode_q    <= mode_req;
        counter_q <= '0;
        tick_q    <= 1'b0;
        phase_q   <= 1'b0;
        led_q     <= (mode_req == MODE_FLASH) ? '0 : LED_ONE;
      end else if (bus.i_enable) begin
        if (terminal) begin
          counter_q <= '0;
          tick_q    <= 1'b1;
          if (mode_q == MODE_SHIFT) begin
            if (dir_q == DIR_LEFT) begin
              led_q <= {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
            end else begin
              led_q <= {led_q[0], led_q[N_LEDS-1:1]};
            end
          end else begin
            // Phase starts off after a load, so the first step lights all.
            phase_q <= ~phase_q;
            led_q   <= phase_q ? '0 : '1;
          end
        end else begin
          counter_q <= counter_q + NB_COUNTER'(1);
          tick_q    <= 1'b0;
        end
      end else begin
        tick_q <= 1'b0;
      end
    end
  end

  assign bus.o_led  = led_q;
  assign bus.o_tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - scoreboard bench for led_pattern_gen

module tb_led_pattern_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  led_pattern_gen_if #(.N_LEDS(4)) ifc ();

  led_pattern_gen #(
    .N_LEDS     (4),
    .NB_COUNTER (32),
    .LIMIT_0    (32'd3),
    .LIMIT_1    (32'd9),
    .LIMIT_2    (32'd5),
    .LIMIT_3    (32'd7)
  ) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (ifc)
  );

  always #5 clk = ~clk;

  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;
  int n_checks = 0;
  int n_fail   = 0;
  int n_ticks  = 0;
  int t0       = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance n falling edges, then step off the edge before driving/sampling.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Monitor: every step strobe must match the next queued pattern word.
  always @(negedge clk) begin
    if (rst_n && ifc.o_tick) begin
      n_ticks++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_tick: led=%b with no step queued", ifc.o_led);
      end else begin
        mon_exp = exp_q.pop_front();
        check("step_led", 32'(ifc.o_led), 32'(mon_exp));
      end
    end
  end

  initial begin
    ifc.i_enable    = 1'b1;
    ifc.i_speed_sel = 2'd0;
    ifc.i_mode      = 1'b0;
    ifc.i_dir_btn   = 1'b0;
    rst_n           = 1'b0;
    cyc(3);
    check("reset_led",  32'(ifc.o_led),  32'h1);
    check("reset_tick", 32'(ifc.o_tick), 32'h0);

    // Rate: tick every 4th cycle, rotating left.
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    t0 = n_ticks;
    rst_n = 1'b1;
    cyc(8);
    check("rate_ticks", 32'(n_ticks - t0), 32'd2);
    check("rate_tick_on_4th", 32'(ifc.o_tick), 32'h1);
    check("rate_led", 32'(ifc.o_led), 32'h4);

    // Direction: one press, toggle lands before the next tick.
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b1000);
    ifc.i_dir_btn = 1'b1;
    t0 = n_ticks;
    cyc(12);
    check("dir_ticks", 32'(n_ticks - t0), 32'd3);
    check("dir_led", 32'(ifc.o_led), 32'h8);
    ifc.i_dir_btn = 1'b0;

    // Flash: load all zeros, then alternate every 4 cycles.
    exp_q.push_back(4'b1111);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b1111);
    ifc.i_mode = 1'b1;
    cyc(1);
    check("flash_load_led",  32'(ifc.o_led),  32'h0);
    check("flash_load_tick", 32'(ifc.o_tick), 32'h0);
    t0 = n_ticks;
    cyc(12);
    check("flash_ticks", 32'(n_ticks - t0), 32'd3);
    check("flash_led", 32'(ifc.o_led), 32'hF);

    // Enable freeze.
    ifc.i_enable = 1'b0;
    t0 = n_ticks;
    cyc(10);
    check("freeze_ticks", 32'(n_ticks - t0), 32'd0);
    check("freeze_led", 32'(ifc.o_led), 32'hF);

    // Speed drop: count reaches 7 under LIMIT_1=9, then LIMIT_0=3 fires at once.
    exp_q.push_back(4'b0000);
    ifc.i_enable    = 1'b1;
    ifc.i_speed_sel = 2'd1;
    t0 = n_ticks;
    cyc(7);
    check("speed1_no_tick", 32'(n_ticks - t0), 32'd0);
    ifc.i_speed_sel = 2'd0;
    cyc(1);
    check("speed_drop_tick", 32'(ifc.o_tick), 32'h1);

    // Back to shift, then a mode change on the terminal-count cycle.
    ifc.i_mode = 1'b0;
    cyc(1);
    check("shift_load_led", 32'(ifc.o_led), 32'h1);
    t0 = n_ticks;
    cyc(3);
    ifc.i_mode = 1'b1;
    cyc(1);
    check("collide_led",  32'(ifc.o_led),  32'h0);
    check("collide_tick", 32'(ifc.o_tick), 32'h0);
    ifc.i_mode = 1'b0;
    cyc(1);
    check("reshift_led", 32'(ifc.o_led), 32'h1);
    exp_q.push_back(4'b1000);
    cyc(4);
    check("collide_ticks", 32'(n_ticks - t0), 32'd1);
    check("dir_kept_led", 32'(ifc.o_led), 32'h8);

    // Asynchronous reset mid-flash, while a tick is high.
    ifc.i_mode = 1'b1;
    cyc(1);
    exp_q.push_back(4'b1111);
    cyc(4);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_led",  32'(ifc.o_led),  32'h1);
    check("async_rst_tick", 32'(ifc.o_tick), 32'h0);
    ifc.i_mode = 1'b0;
    cyc(2);
    exp_q.push_back(4'b0010);
    rst_n = 1'b1;
    cyc(4);
    check("rst_dir_left_led", 32'(ifc.o_led), 32'h2);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Generates the LED pattern word that feeds the ledmux `i_led` input.
- Two patterns:
  - Shift: a single lit LED rotating across the bank.
  - Flash: the whole bank blinking on and off.
- A free-running prescaler with selectable rate sets the step rate; a push-button reverses the shift direction.
- Sits directly upstream of ledmux. `o_led` connects 1:1 to ledmux `i_led`.

Parameters:
- N_LEDS, 4, width of the LED pattern word; must match ledmux N_LEDS; minimum 2.
- NB_COUNTER, 32, prescaler counter width.
- LIMIT_0, 2**23-1, terminal count for speed 0.
- LIMIT_1, 2**24-1, terminal count for speed 1.
- LIMIT_2, 2**25-1, terminal count for speed 2.
- LIMIT_3, 2**26-1, terminal count for speed 3.
- Each LIMIT_k must fit in NB_COUNTER bits. Tick period = LIMIT_k+1 cycles.

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_enable  input  1  1 = pattern runs; 0 = pattern freezes.
- i_speed_sel  input  2  selects LIMIT_0..LIMIT_3.
- i_mode  input  1  0 = shift, 1 = flash; level from a switch, already synchronous.
- i_dir_btn  input  1  raw push-button, asynchronous; each press reverses the shift direction.
- o_led  output  N_LEDS  registered pattern word, to ledmux `i_led`.
- o_tick  output  1  registered one-cycle strobe on every pattern step.

Behaviour:
- Reset (i_rst_n=0, asynchronous assert, synchronous release):
  - counter=0, o_tick=0, o_led=1 (bit0 only), dir=LEFT (toward the MSB).
  - mode_q=0, flash phase=off, synchronizer and edge registers=0.
  - Reset asserted mid-operation returns to this state immediately, regardless of the current pattern.
- Prescaler:
  - When i_enable=1: if counter >= LIMIT(i_speed_sel), then counter<=0 and o_tick<=1; else counter<=counter+1 and o_tick<=0.
  - The comparison is `>=`, not `==`. If the selection drops below the current count, the tick fires on the next cycle. There is no overflow or hang.
  - When i_enable=0: counter holds, o_tick=0, o_led holds. Resuming continues from the held count.
- Pattern update:
  - Occurs in the same cycle that the tick is generated, i.e. o_led and o_tick change together.
  - Shift, dir=LEFT: o_led <= {o_led[N-2:0], o_led[N-1]}. Wraps MSB to bit0.
  - Shift, dir=RIGHT: o_led <= {o_led[0], o_led[N-1:1]}. Wraps bit0 to MSB.
  - Flash: phase toggles. o_led = all ones when phase=on, all zeros when phase=off. The first tick after entering flash gives all ones.
- Mode change:
  - mode_q registers i_mode. When i_mode != mode_q, the next edge:
    - sets mode_q<=i_mode and counter<=0;
    - loads o_led: entering shift loads 1 (bit0) with dir unchanged; entering flash loads all zeros with phase=off.
  - o_tick=0 on the load cycle.
  - If a mode change and a terminal count coincide, the mode load wins and no step occurs.
  - The mode load occurs even when i_enable=0.
- Direction button:
  - Passes through a 2-FF synchronizer, then a rising-edge detect.
  - Each detected edge toggles dir, 3 cycles after the raw rise.
  - No debounce inside this block; bounce produces multiple toggles.
  - dir toggles in flash mode too, with no visible effect until back in shift.
  - A toggle coinciding with a tick: the step uses the old dir; the new dir applies from the next tick.
- Invariants:
  - In shift mode, o_led is always one-hot.
  - In flash mode, o_led is always all ones or all zeros.

Test Plan:
- Rate: LIMIT_0=3, i_speed_sel=0, enable=1, mode=0, from reset -> o_tick high every 4th cycle. o_led sequence 0001, 0010, 0100, 1000, 0001 (wrap).
- Direction: press i_dir_btn when o_led=0100 -> dir toggles 3 cycles after the rise. Subsequent ticks give 0010, 0001, 1000 (wrap).
- Flash: set i_mode=1 while o_led=0100 -> next cycle o_led=0000 and counter=0. After 4 cycles o_led=1111, then 0000, alternating every 4 cycles.
- Enable and speed: deassert enable for 10 cycles -> o_led and counter frozen, no ticks. Set LIMIT_1=9 and switch i_speed_sel 1->0 with counter=7 -> tick on the next cycle.
- Collision: raise i_mode on the exact terminal-count cycle -> mode load only, no extra step. Back to shift -> o_led=0001 with dir preserved.
- Reset: pulse i_rst_n low mid-flash, asynchronous to clk -> o_led=0001, o_tick=0, dir=LEFT immediately.
